map_switch_ctrl: RTL and testbench



---
 rtl/map_switch_pkg.sv | 35 +++
 rtl/map_switch_cnt.sv | 35 +++
 rtl/map_switch_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_map_switch_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/map_switch_pkg.sv
// -----------------------------------------------------------------------------
// map_switch_pkg
// Shared types and constants for the run-time mapper switch sequencer.
//   state_t    : sequencer state encoding (3 bits)
//   DEF_*      : default parameter values
//   cnt_w()    : width of an unsigned counter that must hold max_val
//   max3()     : largest of three integers
// -----------------------------------------------------------------------------
package map_switch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_M2 = 3'd1,
        ST_GATE    = 3'd2,
        ST_RESET   = 3'd3,
        ST_RELEASE = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    localparam int DEF_IDX_W      = 8;
    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_RST_CYC    = 16;
    localparam int DEF_TMO_CYC    = 4096;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/map_switch_cnt.sv
// -----------------------------------------------------------------------------
// map_switch_cnt
// Loadable down-counter that stops at zero. One instance times every timed
// state of the sequencer.
//   i_clk      : system clock
//   i_rst      : asynchronous active-high reset
//   i_load     : load i_load_val this cycle (takes priority over counting)
//   i_load_val : value to load
//   o_zero     : counter currently holds zero
// -----------------------------------------------------------------------------
module map_switch_cnt #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/map_switch_ctrl.sv
// -----------------------------------------------------------------------------
// map_switch_ctrl
// Sequences a run-time mapper change: wait for an M2 falling edge, gate the
// hub outputs, switch the active index, hold mappers in reset, release.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | nothing running; serves a new strobe or a parked request
// WAIT_M2    | waiting for M2 fall (bounded by TMO_CYC)
// GATE       | outputs gated, SETTLE_CYC cycles before reset
// RESET      | new index applied, mappers held in reset for RST_CYC cycles
// RELEASE    | reset released, still gated for SETTLE_CYC cycles
// FINISH     | one-cycle done pulse; serves the pending slot if any
//
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_cfg_stb      : one-cycle strobe, i_cfg_idx valid
//   i_cfg_idx      : requested mapper index
//   i_m2           : CPU phi2, already synchronous to i_clk
//   o_map_idx      : active index for hub select
//   o_out_gate     : hub forces mapper outputs inactive
//   o_map_rst      : all mapper instances held in reset
//   o_busy         : sequence running or request pending
//   o_done         : one-cycle pulse at sequence end
//   o_tmo_err      : sticky, last sequence proceeded on timeout
// -----------------------------------------------------------------------------
module map_switch_ctrl
    import map_switch_pkg::*;
#(
    parameter int IDX_W      = DEF_IDX_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int RST_CYC    = DEF_RST_CYC,
    parameter int TMO_CYC    = DEF_TMO_CYC
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_stb,
    input  logic [IDX_W-1:0] i_cfg_idx,
    input  logic             i_m2,
    output logic [IDX_W-1:0] o_map_idx,
    output logic             o_out_gate,
    output logic             o_map_rst,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_tmo_err
);

    localparam int CNT_W = cnt_w(max3(TMO_CYC, RST_CYC, SETTLE_CYC));
    // Loaded with N-1 on entry so a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] L_WAIT   = CNT_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] L_SETTLE = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] L_RST    = CNT_W'(RST_CYC - 1);

    state_t             r_state, w_next_state;
    logic               r_m2_q;
    logic [IDX_W-1:0]   r_req_idx, r_pend_idx, r_map_idx;
    logic               r_pend_vld, r_tmo_err, r_out_gate, r_map_rst, r_busy, r_done;

    logic               w_m2_fall, w_cnt_zero, w_tmo_hit, w_mid_seq, w_enter;
    logic               w_svc_vld, w_svc_same;
    logic [IDX_W-1:0]   w_svc_idx;
    logic               w_pend_vld_nxt;
    logic [IDX_W-1:0]   w_pend_idx_nxt, w_req_idx_nxt, w_map_idx_nxt;
    logic               w_gate_nxt, w_rst_nxt, w_done_nxt, w_busy_nxt, w_tmo_nxt;
    logic               w_cnt_load;
    logic [CNT_W-1:0]   w_cnt_val;

    assign w_m2_fall  = r_m2_q & ~i_m2;
    assign w_mid_seq  = (r_state inside {ST_WAIT_M2, ST_GATE, ST_RESET, ST_RELEASE});
    // A fresh strobe wins over a parked request (last wins).
    assign w_svc_vld  = i_cfg_stb | r_pend_vld;
    assign w_svc_idx  = i_cfg_stb ? i_cfg_idx : r_pend_idx;
    assign w_svc_same = (w_svc_idx == r_map_idx);

    map_switch_cnt #(.W(CNT_W)) u_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_m2_q     <= 1'b0;
            r_req_idx  <= '0;
            r_pend_vld <= 1'b0;
            r_pend_idx <= '0;
            r_map_idx  <= '0;
            r_tmo_err  <= 1'b0;
            r_out_gate <= 1'b0;
            r_map_rst  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_m2_q     <= i_m2;
            r_req_idx  <= w_req_idx_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_idx <= w_pend_idx_nxt;
            r_map_idx  <= w_map_idx_nxt;
            r_tmo_err  <= w_tmo_nxt;
            r_out_gate <= w_gate_nxt;
            r_map_rst  <= w_rst_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_tmo_hit      = 1'b0;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_idx_nxt = r_pend_idx;
        if (i_cfg_stb && w_mid_seq) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_idx_nxt = i_cfg_idx;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_svc_vld) begin
                    if (!w_svc_same) begin
                        w_next_state   = ST_WAIT_M2;
                        w_pend_vld_nxt = 1'b0;
                    end else if (i_cfg_stb) begin
                        // A no-op strobe is parked for one cycle, then finished.
                        w_pend_vld_nxt = 1'b1;
                        w_pend_idx_nxt = w_svc_idx;
                    end else begin
                        w_next_state   = ST_FINISH;
                        w_pend_vld_nxt = 1'b0;
                    end
                end
            end
            ST_WAIT_M2: begin
                // An edge coinciding with expiry counts as an edge.
                if (w_m2_fall) begin
                    w_next_state = ST_GATE;
                end else if (w_cnt_zero) begin
                    w_next_state = ST_GATE;
                    w_tmo_hit    = 1'b1;
                end
            end
            ST_GATE:    if (w_cnt_zero) w_next_state = ST_RESET;
            ST_RESET:   if (w_cnt_zero) w_next_state = ST_RELEASE;
            ST_RELEASE: if (w_cnt_zero) w_next_state = ST_FINISH;
            ST_FINISH: begin
                w_next_state = ST_IDLE;
                if (w_svc_vld) begin
                    if (!w_svc_same) begin
                        w_next_state   = ST_WAIT_M2;
                        w_pend_vld_nxt = 1'b0;
                    end else begin
                        w_pend_vld_nxt = 1'b1;
                        w_pend_idx_nxt = w_svc_idx;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_enter       = (w_next_state != r_state);
        w_gate_nxt    = (w_next_state inside {ST_GATE, ST_RESET, ST_RELEASE});
        w_rst_nxt     = (w_next_state == ST_RESET);
        w_done_nxt    = (w_next_state == ST_FINISH);
        w_busy_nxt    = (w_next_state != ST_IDLE) || w_pend_vld_nxt;
        w_req_idx_nxt = r_req_idx;
        w_map_idx_nxt = r_map_idx;
        w_tmo_nxt     = r_tmo_err;
        w_cnt_load    = 1'b0;
        w_cnt_val     = '0;
        if (w_enter) begin
            case (w_next_state)
                ST_WAIT_M2: begin
                    w_cnt_load    = 1'b1;
                    w_cnt_val     = L_WAIT;
                    w_req_idx_nxt = w_svc_idx;
                    w_tmo_nxt     = 1'b0;
                end
                ST_GATE: begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = L_SETTLE;
                end
                ST_RESET: begin
                    w_cnt_load    = 1'b1;
                    w_cnt_val     = L_RST;
                    w_map_idx_nxt = r_req_idx;
                end
                ST_RELEASE: begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = L_SETTLE;
                end
                default: ;
            endcase
        end
        if (w_tmo_hit) w_tmo_nxt = 1'b1;
    end

    assign o_map_idx  = r_map_idx;
    assign o_out_gate = r_out_gate;
    assign o_map_rst  = r_map_rst;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_tmo_err  = r_tmo_err;

endmodule

// File: tb/tb_map_switch_ctrl.sv
module tb_map_switch_ctrl;

    localparam int IDX_W = 8;
    localparam int S     = 4;
    localparam int R     = 16;
    localparam int TMO   = 64;

    logic             clk;
    logic             i_rst;
    logic             i_cfg_stb;
    logic [IDX_W-1:0] i_cfg_idx;
    logic             i_m2;
    logic [IDX_W-1:0] o_map_idx;
    logic             o_out_gate, o_map_rst, o_busy, o_done, o_tmo_err;

    map_switch_ctrl #(
        .IDX_W(IDX_W), .SETTLE_CYC(S), .RST_CYC(R), .TMO_CYC(TMO)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_cfg_stb(i_cfg_stb), .i_cfg_idx(i_cfg_idx),
        .i_m2(i_m2), .o_map_idx(o_map_idx), .o_out_gate(o_out_gate),
        .o_map_rst(o_map_rst), .o_busy(o_busy), .o_done(o_done), .o_tmo_err(o_tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int idx; int tmo; } exp_t;
    exp_t sb[$];

    // Planned stimulus and expected output changes, keyed by cycle.
    int stb_plan[int];
    int m2_plan[int];
    int gate_chg[int], rst_chg[int], busy_chg[int], tmo_chg[int], idx_chg[int];

    int n_total = 0;
    int n_bad   = 0;
    int m_cur   = 0;
    int m_tmo   = 0;
    int plan_c  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one served request starting at cycle s.
    task automatic plan_service(input int s, input int idx, input int d, output int dn);
        int n;
        int to;
        exp_t e;
        if (idx == m_cur) begin
            dn = s + 2;
        end else begin
            to = (d > TMO) ? 1 : 0;
            n  = to ? s + TMO : s + d;
            for (int c = s; c < n; c++) m2_plan[c] = 1;
            m2_plan[n] = to;
            tmo_chg[s + 1] = 0;
            if (to != 0) tmo_chg[n + 1] = 1;
            gate_chg[n + 1]         = 1;
            rst_chg[n + 1 + S]      = 1;
            idx_chg[n + 1 + S]      = idx;
            rst_chg[n + 1 + S + R]  = 0;
            dn = n + 1 + 2 * S + R;
            gate_chg[dn] = 0;
            m_cur = idx;
            m_tmo = to;
        end
        e.cyc = dn; e.idx = m_cur; e.tmo = m_tmo;
        sb.push_back(e);
    endtask

    task automatic plan_burst(input int idx0, input int d0, input int ext[$], input int d1,
                              output int fin);
        int s, dn, k, seg, c;
        s = plan_c;
        stb_plan[s] = idx0;
        busy_chg[s + 1] = 1;
        plan_service(s, idx0, d0, dn);
        k = ext.size();
        if (k > 0 && dn - s > 8) begin
            seg = (dn - s) / k;
            for (int j = 0; j < k; j++) begin
                c = s + 1 + j * seg + $urandom_range(seg - 1);
                if (j == k - 1 && $urandom_range(3) == 0) c = dn;
                stb_plan[c] = ext[j];
            end
            plan_service(dn, ext[k - 1], d1, dn);
        end
        busy_chg[dn + 1] = 0;
        fin = dn;
        plan_c = dn + 2 + $urandom_range(3);
    endtask

    function automatic int pick_d();
        int r;
        r = $urandom_range(9);
        if (r < 2) return TMO + 1 + $urandom_range(9);
        if (r == 2) return TMO;
        return 1 + $urandom_range(39);
    endfunction

    task automatic drive_until(input int c_end);
        int c;
        while (cyc < c_end) begin
            @(posedge clk);
            #1;
            c = cyc;
            i_cfg_stb = stb_plan.exists(c);
            i_cfg_idx = stb_plan.exists(c) ? IDX_W'(stb_plan[c]) : IDX_W'($urandom);
            i_m2      = m2_plan.exists(c) ? (m2_plan[c] != 0) : ($urandom_range(1) != 0);
        end
    endtask

    // Monitor: applies planned changes and compares every cycle; pops the
    // scoreboard on each expected done.
    int   e_gate = 0, e_rst = 0, e_busy = 0, e_tmo = 0, e_idx = 0;
    exp_t mon_e;
    initial begin
        int c;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                e_gate = 0; e_rst = 0; e_busy = 0; e_tmo = 0; e_idx = 0;
                chk("rst_out_gate", o_out_gate, 0);
                chk("rst_map_rst", o_map_rst, 0);
                chk("rst_busy", o_busy, 0);
                chk("rst_done", o_done, 0);
                chk("rst_tmo_err", o_tmo_err, 0);
                chk("rst_map_idx", o_map_idx, 0);
            end else begin
                c = cyc;
                if (gate_chg.exists(c)) e_gate = gate_chg[c];
                if (rst_chg.exists(c))  e_rst  = rst_chg[c];
                if (busy_chg.exists(c)) e_busy = busy_chg[c];
                if (tmo_chg.exists(c))  e_tmo  = tmo_chg[c];
                if (idx_chg.exists(c))  e_idx  = idx_chg[c];
                chk("out_gate", o_out_gate, e_gate);
                chk("map_rst", o_map_rst, e_rst);
                chk("busy", o_busy, e_busy);
                chk("tmo_err", o_tmo_err, e_tmo);
                chk("map_idx", o_map_idx, e_idx);
                if (sb.size() > 0 && sb[0].cyc == c) begin
                    mon_e = sb.pop_front();
                    chk("done_pulse", o_done, 1);
                    chk("done_map_idx", o_map_idx, mon_e.idx);
                    chk("done_tmo_err", o_tmo_err, mon_e.tmo);
                end else begin
                    chk("done_idle", o_done, 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int fin, s, dn, idx0, k;
        int noext[$];
        int ext[$];

        i_rst = 1'b1; i_cfg_stb = 1'b0; i_cfg_idx = '0; i_m2 = 1'b0;
        drive_until(3);
        i_rst = 1'b0;
        plan_c = cyc + 2;

        // Canonical switch: index 30, M2 edge 10 cycles after the strobe.
        plan_burst(30, 10, noext, 0, fin);
        drive_until(fin + 1);

        // M2 stuck high: timeout path.
        plan_burst(77, TMO + 20, noext, 0, fin);
        drive_until(fin + 1);

        // Requests during a sequence: last one wins, busy held throughout.
        ext = '{225, 207};
        plan_burst(163, 7, ext, 12, fin);
        drive_until(fin + 1);

        // Same index twice: second is a no-op finish.
        plan_burst(111, 5, noext, 0, fin);
        drive_until(fin + 1);
        plan_burst(111, 5, noext, 0, fin);
        drive_until(fin + 1);

        // Edge in the very cycle the timeout expires.
        plan_burst(9, TMO, noext, 0, fin);
        drive_until(fin + 1);

        // Reset while mapper reset is held, with a request pending.
        s = plan_c;
        stb_plan[s] = 55;
        busy_chg[s + 1] = 1;
        plan_service(s, 55, 5, dn);
        stb_plan[s + 3] = 99;
        drive_until(s + 5 + 1 + S + 5);
        #2;
        i_rst = 1'b1;
        #1;
        chk("async_out_gate", o_out_gate, 0);
        chk("async_map_rst", o_map_rst, 0);
        chk("async_busy", o_busy, 0);
        chk("async_map_idx", o_map_idx, 0);
        stb_plan.delete(); m2_plan.delete();
        gate_chg.delete(); rst_chg.delete(); busy_chg.delete();
        tmo_chg.delete(); idx_chg.delete();
        sb.delete();
        m_cur = 0; m_tmo = 0;
        drive_until(cyc + 2);
        i_rst = 1'b0;
        plan_c = cyc + 3;
        drive_until(cyc + 2);

        plan_burst(200, 6, noext, 0, fin);
        drive_until(fin + 1);

        // Randomised bursts.
        for (int it = 0; it < 30; it++) begin
            idx0 = ($urandom_range(3) == 0) ? m_cur : int'($urandom_range(255));
            ext.delete();
            if ($urandom_range(2) == 0) begin
                k = 1 + $urandom_range(2);
                for (int j = 0; j < k; j++) ext.push_back(int'($urandom_range(255)));
                if ($urandom_range(3) == 0) ext[k - 1] = idx0;
            end
            plan_burst(idx0, pick_d(), ext, pick_d(), fin);
            drive_until(fin + 1);
        end

        drive_until(cyc + 5);
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
